// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with two write ports, NUM_RD combinational
// read ports, optional hardwired-zero entry 0, and a one-entry-per-cycle clear engine.
// The clear engine runs after reset and on clr_req. Ready stays low until the clear completes.
// Optional feature macro: REGFILE_BYPASS_EN enables same-cycle write-to-read forwarding.
module regfile_mp #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int NUM_RD  = 2,
    parameter int ZERO_R0 = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr_req,
    output logic                     ready,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        waddr0,
    input  logic [DATA_W-1:0]        wdata0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        waddr1,
    input  logic [DATA_W-1:0]        wdata1,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t              state;
    logic [ADDR_W:0]     clr_ptr;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                zero_r0;
    logic                clr_last;
    logic                clr_wr;
    logic                run_wr;
    logic                wr0_ok;
    logic                wr1_ok;

    // Entry 0 handling, last-entry detection and qualified write strobes
    always_comb begin
        zero_r0  = (ZERO_R0 != 0);
        clr_last = (clr_ptr[ADDR_W-1:0] == ADDR_W'(DEPTH - 1));
        clr_wr   = rst_n && (state == CLEAR);
        // A clear request in RUN swallows any write presented in the same cycle
        run_wr   = rst_n && (state == RUN) && !clr_req;
        wr0_ok   = run_wr && we0 && !(zero_r0 && (waddr0 == '0));
        wr1_ok   = run_wr && we1 && !(zero_r0 && (waddr1 == '0));
    end

    // Control FSM: sequences the clear and drives the registered ready flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= CLEAR;
            clr_ptr <= '0;
            ready   <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    if (clr_req) begin
                        clr_ptr <= '0;
                    end else begin
                        clr_ptr <= clr_ptr + 1'b1;
                        if (clr_last) begin
                            state <= RUN;
                            ready <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    // clr_ptr holds its terminal value while running
                    if (clr_req) begin
                        state   <= CLEAR;
                        clr_ptr <= '0;
                        ready   <= 1'b0;
                    end
                end
                default: begin
                    state   <= CLEAR;
                    clr_ptr <= '0;
                    ready   <= 1'b0;
                end
            endcase
        end
    end

    // Storage array: clear engine owns it during CLEAR, write ports during RUN (port 1 wins)
    always_ff @(posedge clk) begin
        if (clr_wr) begin
            mem[clr_ptr[ADDR_W-1:0]] <= '0;
        end else begin
            if (wr0_ok) begin
                mem[waddr0] <= wdata0;
            end
            if (wr1_ok) begin
                mem[waddr1] <= wdata1;
            end
        end
    end

    // Combinational read ports; zero during CLEAR and for entry 0 when hardwired
    always_comb begin
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd;
        rdata = '0;
        ra    = '0;
        rd    = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            ra = raddr[k*ADDR_W +: ADDR_W];
            rd = '0;
            if ((state == RUN) && !(zero_r0 && (ra == '0))) begin
                rd = mem[ra];
`ifdef REGFILE_BYPASS_EN
                if (we0 && (waddr0 == ra)) begin
                    rd = wdata0;
                end
                if (we1 && (waddr1 == ra)) begin
                    rd = wdata1;
                end
`endif
            end
            rdata[k*DATA_W +: DATA_W] = rd;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Testbench for regfile_mp: directed scenarios followed by randomized traffic,
// all checked against a behavioural model of the register file.
module tb_regfile_mp;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 5;
    localparam int NUM_RD  = 2;
    localparam int ZERO_R0 = 1;
    localparam int DEPTH   = 2 ** ADDR_W;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     clr_req;
    logic                     ready;
    logic                     we0;
    logic [ADDR_W-1:0]        waddr0;
    logic [DATA_W-1:0]        wdata0;
    logic                     we1;
    logic [ADDR_W-1:0]        waddr1;
    logic [DATA_W-1:0]        wdata1;
    logic [NUM_RD*ADDR_W-1:0] raddr;
    logic [NUM_RD*DATA_W-1:0] rdata;

    regfile_mp #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD),
        .ZERO_R0(ZERO_R0)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_req(clr_req),
        .ready  (ready),
        .we0    (we0),
        .waddr0 (waddr0),
        .wdata0 (wdata0),
        .we1    (we1),
        .waddr1 (waddr1),
        .wdata1 (wdata1),
        .raddr  (raddr),
        .rdata  (rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit started  = 1'b0;

    // Reference model: contents, usable flag and clear cycles still to run
    logic [DATA_W-1:0] m_mem [DEPTH];
    bit                m_ready = 1'b0;
    int                m_left  = DEPTH;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] exp_rd(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] r;
        if (!m_ready || (ZERO_R0 != 0 && a == 0)) return '0;
        r = m_mem[a];
`ifdef REGFILE_BYPASS_EN
        if (we0 && waddr0 == a) r = wdata0;
        if (we1 && waddr1 == a) r = wdata1;
`endif
        return r;
    endfunction

    task automatic model_update();
        if (!rst_n) begin
            m_ready = 1'b0;
            m_left  = DEPTH;
        end else if (!m_ready) begin
            if (clr_req) begin
                m_left = DEPTH;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_ready = 1'b1;
                    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
                end
            end
        end else if (clr_req) begin
            m_ready = 1'b0;
            m_left  = DEPTH;
        end else begin
            if (we0 && !(ZERO_R0 != 0 && waddr0 == 0)) m_mem[waddr0] = wdata0;
            if (we1 && !(ZERO_R0 != 0 && waddr1 == 0)) m_mem[waddr1] = wdata1;
        end
    endtask

    // One clock: check outputs against the model, take the edge, advance the model
    task automatic tick();
        #1;
        if (started) begin
            check("ready", ready, m_ready);
            for (int k = 0; k < NUM_RD; k++)
                check($sformatf("rdata%0d", k), rdata[k*DATA_W +: DATA_W],
                      exp_rd(raddr[k*ADDR_W +: ADDR_W]));
        end
        @(posedge clk);
        model_update();
        started = 1'b1;
        #1;
    endtask

    task automatic idle();
        clr_req = 1'b0;
        we0 = 1'b0; waddr0 = '0; wdata0 = '0;
        we1 = 1'b0; waddr1 = '0; wdata1 = '0;
    endtask

    task automatic peek(input string tag, input int k, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] exp);
        raddr[k*ADDR_W +: ADDR_W] = a;
        #1;
        check(tag, rdata[k*DATA_W +: DATA_W], exp);
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!ready && n < 100) begin
            tick();
            n++;
        end
        check(tag, n, DEPTH);
    endtask

    initial begin
        rst_n = 1'b0;
        raddr = '0;
        idle();

        // Reset held for 3 clocks, then a full clear
        repeat (3) tick();
        check("rst_ready", ready, 1'b0);
        peek("rst_rd0", 0, 5'd5, '0);
        peek("rst_rd1", 1, 5'd9, '0);
        rst_n = 1'b1;
        wait_ready("rst_clear_len");

        // Basic write/read and hardwired zero
        we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF;
        tick();
        idle();
        peek("wr5", 0, 5'd5, 32'hDEADBEEF);
        we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'h1234;
        tick();
        idle();
        peek("zero_r0", 0, 5'd0, '0);

        // Same-address collision and distinct-address dual write
        we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'hA;
        we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'hB;
        tick();
        we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h33;
        we1 = 1'b1; waddr1 = 5'd4; wdata1 = 32'h44;
        tick();
        idle();
        peek("collide7", 0, 5'd7, 32'hB);
        peek("dual3", 0, 5'd3, 32'h33);
        peek("dual4", 1, 5'd4, 32'h44);

        // Same-cycle read of an address being written
        we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h11;
        tick();
        idle();
        we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h55;
`ifdef REGFILE_BYPASS_EN
        peek("bypass9", 1, 5'd9, 32'h55);
`else
        peek("nobypass9", 1, 5'd9, 32'h11);
`endif
        tick();
        idle();
        peek("after9", 1, 5'd9, 32'h55);

        // Fill, then clear request with a write in the request cycle
        for (int i = 1; i < DEPTH; i++) begin
            we0 = 1'b1; waddr0 = ADDR_W'(i); wdata0 = 32'h01010101 * i;
            tick();
        end
        idle();
        peek("fill31", 0, 5'd31, 32'h01010101 * 31);
        clr_req = 1'b1;
        we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h77;
        tick();
        idle();
        check("clr_ready_low", ready, 1'b0);
        peek("clr_rd_zero", 0, 5'd31, '0);
        wait_ready("clr_len");
        for (int a = 0; a < DEPTH; a++)
            peek($sformatf("cleared%0d", a), a % NUM_RD, ADDR_W'(a), '0);

        // Reset in the middle of a clear restarts it
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (10) tick();
        rst_n = 1'b0;
        tick();
        check("midclr_ready", ready, 1'b0);
        rst_n = 1'b1;
        wait_ready("midclr_len");

        // Randomized traffic with occasional clear requests and resets
        for (int c = 0; c < 1500; c++) begin
            rst_n   = ($urandom_range(0, 299) != 0);
            clr_req = ($urandom_range(0, 149) == 0);
            we0     = $urandom_range(0, 1);
            we1     = $urandom_range(0, 1);
            waddr0  = ADDR_W'($urandom);
            waddr1  = ($urandom_range(0, 3) == 0) ? waddr0 : ADDR_W'($urandom);
            wdata0  = $urandom;
            wdata1  = $urandom;
            for (int k = 0; k < NUM_RD; k++) begin
                case ($urandom_range(0, 3))
                    0:       raddr[k*ADDR_W +: ADDR_W] = waddr0;
                    1:       raddr[k*ADDR_W +: ADDR_W] = waddr1;
                    default: raddr[k*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
                endcase
            end
            tick();
        end
        rst_n = 1'b1;
        idle();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
